// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation station: field widths, default depth, op codes,
// entry layout and the CDB operand snoop helper.
package alu_rs_pkg;

  localparam int unsigned OP_LEN      = 4;
  localparam int unsigned IMM_LEN     = 32;
  localparam int unsigned PC_LEN      = 32;
  localparam int unsigned ROB_LEN     = 4;
  localparam int unsigned INT_LEN     = 32;
  localparam int unsigned RS_SIZE_DEF = 8;
  localparam int unsigned RS_IDX_LEN  = $clog2(RS_SIZE_DEF);

  typedef enum logic [OP_LEN-1:0] {
    OpAdd  = 4'd0,
    OpSub  = 4'd1,
    OpAnd  = 4'd2,
    OpOr   = 4'd3,
    OpXor  = 4'd4,
    OpSll  = 4'd5,
    OpSrl  = 4'd6,
    OpSra  = 4'd7,
    OpSlt  = 4'd8,
    OpSltu = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic               busy;
    logic [ROB_LEN-1:0] tag;
    logic [INT_LEN-1:0] val;
  } operand_t;

  typedef struct packed {
    logic               valid;
    logic [OP_LEN-1:0]  op;
    logic [IMM_LEN-1:0] imm;
    logic [PC_LEN-1:0]  pc;
    logic [ROB_LEN-1:0] robpos;
    operand_t           opj;
    operand_t           opk;
  } rs_entry_t;

  // A busy operand picks up a matching broadcast; cdb0 takes precedence over cdb1.
  function automatic operand_t snoop(input operand_t           opnd,
                                     input logic               c0_valid,
                                     input logic [ROB_LEN-1:0] c0_robpos,
                                     input logic [INT_LEN-1:0] c0_val,
                                     input logic               c1_valid,
                                     input logic [ROB_LEN-1:0] c1_robpos,
                                     input logic [INT_LEN-1:0] c1_val);
    operand_t res;
    res = opnd;
    if (opnd.busy) begin
      if (c0_valid && (c0_robpos == opnd.tag)) begin
        res.busy = 1'b0;
        res.val  = c0_val;
      end else if (c1_valid && (c1_robpos == opnd.tag)) begin
        res.busy = 1'b0;
        res.val  = c1_val;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_rs_select.sv
// Issue selection: picks one eligible entry as a one-hot grant. With ALU_RS_AGE_PRIO_EN the
// oldest eligible entry wins (older[i][j] set when i was dispatched before j), else lowest index.
module alu_rs_select #(
  parameter int unsigned NumEntries = 8
) (
  input  logic [NumEntries-1:0]                 eligible,
`ifdef ALU_RS_AGE_PRIO_EN
  input  logic [NumEntries-1:0][NumEntries-1:0] older,
`endif
  output logic [NumEntries-1:0]                 grant,
  output logic                                  grant_valid
);

`ifdef ALU_RS_AGE_PRIO_EN
  always_comb begin
    for (int i = 0; i < NumEntries; i++) begin
      grant[i] = eligible[i];
      for (int j = 0; j < NumEntries; j++) begin
        if ((i != j) && eligible[j] && !older[i][j]) begin
          grant[i] = 1'b0;
        end
      end
    end
  end
`else
  // Isolate the lowest set bit.
  assign grant = eligible & (~eligible + NumEntries'(1));
`endif

  assign grant_valid = |eligible;

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops until both operands arrive over the CDBs, then
// issues one per cycle to a registered ALU port. Define ALU_RS_AGE_PRIO_EN for oldest-first issue.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int unsigned RS_SIZE = RS_SIZE_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ready,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [OP_LEN-1:0]  in_op,
  input  logic [IMM_LEN-1:0] in_imm,
  input  logic [PC_LEN-1:0]  in_pc,
  input  logic [ROB_LEN-1:0] in_robpos,
  input  logic               in_qj_busy,
  input  logic               in_qk_busy,
  input  logic [ROB_LEN-1:0] in_qj,
  input  logic [ROB_LEN-1:0] in_qk,
  input  logic [INT_LEN-1:0] in_vj,
  input  logic [INT_LEN-1:0] in_vk,
  input  logic               cdb0_valid,
  input  logic [ROB_LEN-1:0] cdb0_robpos,
  input  logic [INT_LEN-1:0] cdb0_val,
  input  logic               cdb1_valid,
  input  logic [ROB_LEN-1:0] cdb1_robpos,
  input  logic [INT_LEN-1:0] cdb1_val,
  output logic               rs_full,
  output logic               work,
  output logic [OP_LEN-1:0]  op,
  output logic [IMM_LEN-1:0] imm,
  output logic [PC_LEN-1:0]  pc,
  output logic [ROB_LEN-1:0] robpos,
  output logic [INT_LEN-1:0] rs1,
  output logic [INT_LEN-1:0] rs2
);

  localparam int unsigned IdxW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  rs_entry_t           entry_q [RS_SIZE];
  rs_entry_t           entry_d [RS_SIZE];
  rs_entry_t           new_entry;
  rs_entry_t           sel_entry;
  logic [RS_SIZE-1:0]  valid_vec;
  logic [RS_SIZE-1:0]  eligible;
  logic [RS_SIZE-1:0]  grant;
  logic                grant_valid;
  logic [IdxW-1:0]     free_idx;
  logic [IdxW-1:0]     grant_idx;
  logic                free_found;
  logic                dispatch;

  logic               work_q;
  logic [OP_LEN-1:0]  op_q;
  logic [IMM_LEN-1:0] imm_q;
  logic [PC_LEN-1:0]  pc_q;
  logic [ROB_LEN-1:0] robpos_q;
  logic [INT_LEN-1:0] rs1_q;
  logic [INT_LEN-1:0] rs2_q;

  // Eligibility is taken from registered state only, so a wakeup or dispatch captured at an edge
  // can be selected no earlier than the following cycle.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      valid_vec[i] = entry_q[i].valid;
      eligible[i]  = entry_q[i].valid && !entry_q[i].opj.busy && !entry_q[i].opk.busy;
    end
  end

  assign rs_full  = &valid_vec;
  assign dispatch = ready && in_valid && !rs_full && !clear;

  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!valid_vec[i] && !free_found) begin
        free_idx   = IdxW'(i);
        free_found = 1'b1;
      end
    end
  end

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (grant[i]) begin
        grant_idx = IdxW'(i);
      end
    end
  end

  assign sel_entry = entry_q[grant_idx];

`ifdef ALU_RS_AGE_PRIO_EN
  logic [RS_SIZE-1:0][RS_SIZE-1:0] older_q;
  logic [RS_SIZE-1:0][RS_SIZE-1:0] older_d;

  // A new entry is younger than every other slot; relations between other slots are untouched.
  always_comb begin
    older_d = older_q;
    if (dispatch) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (free_idx == IdxW'(i)) begin
          older_d[i] = '0;
        end else begin
          older_d[i][free_idx] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      older_q <= '0;
    end else begin
      older_q <= older_d;
    end
  end
`endif

  alu_rs_select #(
    .NumEntries (RS_SIZE)
  ) u_select (
    .eligible    (eligible),
`ifdef ALU_RS_AGE_PRIO_EN
    .older       (older_q),
`endif
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  always_comb begin
    new_entry        = '0;
    new_entry.valid  = 1'b1;
    new_entry.op     = in_op;
    new_entry.imm    = in_imm;
    new_entry.pc     = in_pc;
    new_entry.robpos = in_robpos;
    new_entry.opj    = snoop('{busy: in_qj_busy, tag: in_qj, val: in_vj},
                             cdb0_valid, cdb0_robpos, cdb0_val,
                             cdb1_valid, cdb1_robpos, cdb1_val);
    new_entry.opk    = snoop('{busy: in_qk_busy, tag: in_qk, val: in_vk},
                             cdb0_valid, cdb0_robpos, cdb0_val,
                             cdb1_valid, cdb1_robpos, cdb1_val);
  end

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      entry_d[i] = entry_q[i];
      if (clear) begin
        entry_d[i].valid = 1'b0;
      end else if (ready) begin
        entry_d[i].opj = snoop(entry_q[i].opj, cdb0_valid, cdb0_robpos, cdb0_val,
                               cdb1_valid, cdb1_robpos, cdb1_val);
        entry_d[i].opk = snoop(entry_q[i].opk, cdb0_valid, cdb0_robpos, cdb0_val,
                               cdb1_valid, cdb1_robpos, cdb1_val);
        if (grant[i]) begin
          entry_d[i].valid = 1'b0;
        end
        if (dispatch && (free_idx == IdxW'(i))) begin
          entry_d[i] = new_entry;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      work_q   <= 1'b0;
      op_q     <= '0;
      imm_q    <= '0;
      pc_q     <= '0;
      robpos_q <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
    end else if (clear) begin
      work_q <= 1'b0;
    end else if (ready) begin
      work_q <= grant_valid;
      if (grant_valid) begin
        op_q     <= sel_entry.op;
        imm_q    <= sel_entry.imm;
        pc_q     <= sel_entry.pc;
        robpos_q <= sel_entry.robpos;
        rs1_q    <= sel_entry.opj.val;
        rs2_q    <= sel_entry.opk.val;
      end
    end
  end

  assign work   = work_q;
  assign op     = op_q;
  assign imm    = imm_q;
  assign pc     = pc_q;
  assign robpos = robpos_q;
  assign rs1    = rs1_q;
  assign rs2    = rs2_q;

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios plus randomized traffic, all compared
// cycle by cycle against a slot/sequence-number reference model.
module tb_alu_rs;
  import alu_rs_pkg::*;

  localparam int RS = 8;

  logic               clk;
  logic               reset_n;
  logic               ready;
  logic               clear;
  logic               in_valid;
  logic [OP_LEN-1:0]  in_op;
  logic [IMM_LEN-1:0] in_imm;
  logic [PC_LEN-1:0]  in_pc;
  logic [ROB_LEN-1:0] in_robpos;
  logic               in_qj_busy;
  logic               in_qk_busy;
  logic [ROB_LEN-1:0] in_qj;
  logic [ROB_LEN-1:0] in_qk;
  logic [INT_LEN-1:0] in_vj;
  logic [INT_LEN-1:0] in_vk;
  logic               cdb0_valid;
  logic [ROB_LEN-1:0] cdb0_robpos;
  logic [INT_LEN-1:0] cdb0_val;
  logic               cdb1_valid;
  logic [ROB_LEN-1:0] cdb1_robpos;
  logic [INT_LEN-1:0] cdb1_val;
  logic               rs_full;
  logic               work;
  logic [OP_LEN-1:0]  op;
  logic [IMM_LEN-1:0] imm;
  logic [PC_LEN-1:0]  pc;
  logic [ROB_LEN-1:0] robpos;
  logic [INT_LEN-1:0] rs1;
  logic [INT_LEN-1:0] rs2;

  alu_rs #(
    .RS_SIZE (RS)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ready       (ready),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_op       (in_op),
    .in_imm      (in_imm),
    .in_pc       (in_pc),
    .in_robpos   (in_robpos),
    .in_qj_busy  (in_qj_busy),
    .in_qk_busy  (in_qk_busy),
    .in_qj       (in_qj),
    .in_qk       (in_qk),
    .in_vj       (in_vj),
    .in_vk       (in_vk),
    .cdb0_valid  (cdb0_valid),
    .cdb0_robpos (cdb0_robpos),
    .cdb0_val    (cdb0_val),
    .cdb1_valid  (cdb1_valid),
    .cdb1_robpos (cdb1_robpos),
    .cdb1_val    (cdb1_val),
    .rs_full     (rs_full),
    .work        (work),
    .op          (op),
    .imm         (imm),
    .pc          (pc),
    .robpos      (robpos),
    .rs1         (rs1),
    .rs2         (rs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per-slot contents plus a dispatch sequence number for age ordering.
  bit                 m_valid [RS];
  logic [OP_LEN-1:0]  m_op    [RS];
  logic [IMM_LEN-1:0] m_imm   [RS];
  logic [PC_LEN-1:0]  m_pc    [RS];
  logic [ROB_LEN-1:0] m_rob   [RS];
  bit                 m_jb    [RS];
  logic [ROB_LEN-1:0] m_qj    [RS];
  logic [INT_LEN-1:0] m_vj    [RS];
  bit                 m_kb    [RS];
  logic [ROB_LEN-1:0] m_qk    [RS];
  logic [INT_LEN-1:0] m_vk    [RS];
  int                 m_seq   [RS];
  int                 seq_ctr;
  bit                 m_work;
  logic [OP_LEN-1:0]  m_o_op;
  logic [IMM_LEN-1:0] m_o_imm;
  logic [PC_LEN-1:0]  m_o_pc;
  logic [ROB_LEN-1:0] m_o_rob;
  logic [INT_LEN-1:0] m_o_rs1;
  logic [INT_LEN-1:0] m_o_rs2;

  // Returns {still_busy, value} after looking at this cycle's broadcasts.
  function automatic logic [INT_LEN:0] resolve(input bit busy, input logic [ROB_LEN-1:0] tag,
                                                input logic [INT_LEN-1:0] val);
    if (busy && cdb0_valid && cdb0_robpos == tag) return {1'b0, cdb0_val};
    if (busy && cdb1_valid && cdb1_robpos == tag) return {1'b0, cdb1_val};
    return {busy, val};
  endfunction

  function automatic bit model_full();
    for (int i = 0; i < RS; i++) if (!m_valid[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < RS; i++) m_valid[i] = 1'b0;
    seq_ctr = 0;
    m_work  = 1'b0;
    m_o_op  = '0;
    m_o_imm = '0;
    m_o_pc  = '0;
    m_o_rob = '0;
    m_o_rs1 = '0;
    m_o_rs2 = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit               full;
    int               pick;
    int               freei;
    logic [INT_LEN:0] r;
    if (clear) begin
      for (int i = 0; i < RS; i++) m_valid[i] = 1'b0;
      m_work = 1'b0;
      return;
    end
    if (!ready) return;
    full = model_full();
    pick = -1;
    for (int i = 0; i < RS; i++) begin
      if (m_valid[i] && !m_jb[i] && !m_kb[i]) begin
`ifdef ALU_RS_AGE_PRIO_EN
        if (pick < 0 || m_seq[i] < m_seq[pick]) pick = i;
`else
        if (pick < 0) pick = i;
`endif
      end
    end
    freei = -1;
    for (int i = 0; i < RS; i++) if (!m_valid[i] && freei < 0) freei = i;
    for (int i = 0; i < RS; i++) begin
      if (m_valid[i]) begin
        r = resolve(m_jb[i], m_qj[i], m_vj[i]);
        m_jb[i] = r[INT_LEN];
        m_vj[i] = r[INT_LEN-1:0];
        r = resolve(m_kb[i], m_qk[i], m_vk[i]);
        m_kb[i] = r[INT_LEN];
        m_vk[i] = r[INT_LEN-1:0];
      end
    end
    if (pick >= 0) begin
      m_work        = 1'b1;
      m_o_op        = m_op[pick];
      m_o_imm       = m_imm[pick];
      m_o_pc        = m_pc[pick];
      m_o_rob       = m_rob[pick];
      m_o_rs1       = m_vj[pick];
      m_o_rs2       = m_vk[pick];
      m_valid[pick] = 1'b0;
    end else begin
      m_work = 1'b0;
    end
    if (in_valid && !full) begin
      m_valid[freei] = 1'b1;
      m_op[freei]    = in_op;
      m_imm[freei]   = in_imm;
      m_pc[freei]    = in_pc;
      m_rob[freei]   = in_robpos;
      m_qj[freei]    = in_qj;
      m_qk[freei]    = in_qk;
      r = resolve(in_qj_busy, in_qj, in_vj);
      m_jb[freei] = r[INT_LEN];
      m_vj[freei] = r[INT_LEN-1:0];
      r = resolve(in_qk_busy, in_qk, in_vk);
      m_kb[freei] = r[INT_LEN];
      m_vk[freei] = r[INT_LEN-1:0];
      m_seq[freei] = seq_ctr;
      seq_ctr++;
    end
  endtask

  task automatic compare_all();
    check_eq("rs_full", rs_full, model_full());
    check_eq("work", work, m_work);
    check_eq("op", op, m_o_op);
    check_eq("imm", imm, m_o_imm);
    check_eq("pc", pc, m_o_pc);
    check_eq("robpos", robpos, m_o_rob);
    check_eq("rs1", rs1, m_o_rs1);
    check_eq("rs2", rs2, m_o_rs2);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    ready      = 1'b1;
    clear      = 1'b0;
    in_valid   = 1'b0;
    cdb0_valid = 1'b0;
    cdb1_valid = 1'b0;
  endtask

  task automatic disp(input logic [OP_LEN-1:0] o, input logic [ROB_LEN-1:0] rob,
                      input bit jb, input logic [ROB_LEN-1:0] qj, input logic [INT_LEN-1:0] vj,
                      input bit kb, input logic [ROB_LEN-1:0] qk, input logic [INT_LEN-1:0] vk);
    in_valid   = 1'b1;
    in_op      = o;
    in_robpos  = rob;
    in_imm     = $urandom;
    in_pc      = $urandom;
    in_qj_busy = jb;
    in_qj      = qj;
    in_vj      = vj;
    in_qk_busy = kb;
    in_qk      = qk;
    in_vk      = vk;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    reset_n = 1'b1;
    idle();
  endtask

  logic [ROB_LEN-1:0] exp_first;
  logic [ROB_LEN-1:0] exp_second;

  initial begin
    reset_n = 1'b0;
    idle();
    disp(OpAdd, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    cdb0_robpos = '0; cdb0_val = '0; cdb1_robpos = '0; cdb1_val = '0;

    // Basic dispatch and issue latency.
    do_reset();
    disp(OpAdd, 3, 0, 0, 5, 0, 0, 7);
    tick();
    check_eq("add_not_yet", work, 1'b0);
    idle();
    tick();
    check_eq("add_work", work, 1'b1);
    check_eq("add_op", op, OpAdd);
    check_eq("add_rs1", rs1, 5);
    check_eq("add_rs2", rs2, 7);
    check_eq("add_rob", robpos, 3);

    // Wakeup from cdb1.
    do_reset();
    disp(OpSub, 1, 1, 2, 0, 0, 0, 1);
    tick();
    idle();
    tick();
    cdb1_valid = 1'b1; cdb1_robpos = 2; cdb1_val = 32'h10;
    tick();
    check_eq("wake_wait", work, 1'b0);
    idle();
    tick();
    check_eq("wake_work", work, 1'b1);
    check_eq("wake_rs1", rs1, 32'h10);

    // Fill all slots, overflow drop, then back-to-back issue.
    do_reset();
    for (int i = 0; i < RS; i++) begin
      disp(OpAnd, ROB_LEN'(i), 1, 6, 0, 0, 0, 32'(i));
      tick();
    end
    check_eq("full_set", rs_full, 1'b1);
    disp(OpOr, 9, 0, 0, 1, 0, 0, 1);
    tick();
    check_eq("full_drop_work", work, 1'b0);
    idle();
    cdb0_valid = 1'b1; cdb0_robpos = 6; cdb0_val = 32'h66;
    tick();
    idle();
    for (int i = 0; i < RS; i++) begin
      tick();
      check_eq("drain_work", work, 1'b1);
      check_eq("drain_rob", robpos, ROB_LEN'(i));
    end
    tick();
    check_eq("drain_done", work, 1'b0);

    // Issue priority between two entries waking together.
    do_reset();
    disp(OpXor, 10, 1, 7, 0, 0, 0, 0);
    tick();
    disp(OpXor, 5, 1, 1, 0, 0, 0, 0);
    tick();
    idle();
    cdb0_valid = 1'b1; cdb0_robpos = 7; cdb0_val = 32'h7;
    tick();
    idle();
    tick();
    check_eq("prio_filler", robpos, 10);
    disp(OpXor, 4, 1, 1, 0, 0, 0, 0);
    tick();
    idle();
    cdb0_valid = 1'b1; cdb0_robpos = 1; cdb0_val = 32'h1;
    tick();
    idle();
`ifdef ALU_RS_AGE_PRIO_EN
    exp_first = 5; exp_second = 4;
`else
    exp_first = 4; exp_second = 5;
`endif
    tick();
    check_eq("prio_first", robpos, exp_first);
    tick();
    check_eq("prio_second", robpos, exp_second);

    // Flush with a dispatch in the same cycle.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      disp(OpSll, ROB_LEN'(i), 1, 9, 0, 0, 0, 0);
      tick();
    end
    disp(OpSll, 12, 0, 0, 1, 0, 0, 1);
    clear = 1'b1;
    tick();
    check_eq("clear_full", rs_full, 1'b0);
    check_eq("clear_work", work, 1'b0);
    idle();
    cdb0_valid = 1'b1; cdb0_robpos = 9; cdb0_val = 32'h9;
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("clear_quiet", work, 1'b0);
    end

    // Stall: ready low freezes everything.
    do_reset();
    disp(OpSrl, 1, 0, 0, 11, 0, 0, 12);
    tick();
    disp(OpSrl, 2, 0, 0, 21, 0, 0, 22);
    tick();
    disp(OpSra, 3, 0, 0, 31, 0, 0, 32);
    ready = 1'b0;
    cdb0_valid = 1'b1; cdb0_robpos = 2; cdb0_val = 32'hbad;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_work", work, 1'b1);
      check_eq("stall_rob", robpos, 1);
    end
    idle();
    tick();
    check_eq("resume_rob", robpos, 2);
    check_eq("resume_rs1", rs1, 21);

    // Randomized traffic with a mid-run reset.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c == 300) do_reset();
      ready      = ($urandom_range(0, 9) != 0);
      clear      = ($urandom_range(0, 39) == 0);
      in_valid   = ($urandom_range(0, 9) < 6);
      in_op      = OP_LEN'($urandom_range(0, 9));
      in_robpos  = ROB_LEN'($urandom);
      in_imm     = $urandom;
      in_pc      = $urandom;
      in_qj_busy = $urandom_range(0, 1);
      in_qk_busy = $urandom_range(0, 1);
      in_qj      = ROB_LEN'($urandom_range(0, 7));
      in_qk      = ROB_LEN'($urandom_range(0, 7));
      in_vj      = $urandom;
      in_vk      = $urandom;
      cdb0_valid = ($urandom_range(0, 9) < 4);
      cdb0_robpos = ROB_LEN'($urandom_range(0, 7));
      cdb0_val   = $urandom;
      cdb1_valid = ($urandom_range(0, 9) < 4);
      cdb1_robpos = ROB_LEN'($urandom_range(0, 7));
      cdb1_val   = $urandom;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 Parameter RS_SIZE, default 8, number of entries; power of two, 2..16.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 ready  input  1  global advance enable; low freezes all state.
REQ-005 clear  input  1  mispredict flush.
REQ-006 in_valid  input  1  dispatch request from decoder.
REQ-007 in_op/in_imm/in_pc/in_robpos  input  OP_LEN/IMM_LEN/PC_LEN/ROB_LEN  decoded fields.
REQ-008 in_qj_busy/in_qk_busy  input  1  operand waits on ROB tag.
REQ-009 in_qj/in_qk  input  ROB_LEN  producer tags.
REQ-010 in_vj/in_vk  input  INT_LEN  operand values, used when not busy.
REQ-011 cdb0_valid/cdb0_robpos/cdb0_val  input  1/ROB_LEN/INT_LEN  ALU result broadcast.
REQ-012 cdb1_valid/cdb1_robpos/cdb1_val  input  1/ROB_LEN/INT_LEN  load/store broadcast.
REQ-013 rs_full  output  1  no free entry.
REQ-014 work/op/imm/pc/robpos/rs1/rs2  output  1/OP_LEN/IMM_LEN/PC_LEN/ROB_LEN/INT_LEN/INT_LEN  registered issue port to ALU.

Function
REQ-015 Entry holds valid, op, imm, pc, robpos, qj_busy, qj, vj, qk_busy, qk, vk.
REQ-016 rs_full combinational: all RS_SIZE entries valid.
REQ-017 Dispatch accepted when ready && in_valid && !rs_full && !clear; written to lowest-index free entry.
REQ-018 Dispatch with an issue in the same cycle while full: rejected; freed slot usable next cycle.
REQ-019 Wakeup: valid entry with busy operand whose tag equals a valid cdbN_robpos captures cdbN_val and clears busy at the edge.
REQ-020 Dispatch-cycle bypass: an incoming busy operand matching a valid CDB in the same cycle is written not-busy with the CDB value.
REQ-021 Both CDBs matching one tag: cdb0 wins.
REQ-022 Entry eligible when valid, both operands not busy, and written on an earlier edge; wakeup captured this edge counts next cycle.
REQ-023 Each ready cycle, at most one eligible entry is selected; at the edge the selected fields load into outputs, work<=1, entry invalidated.
REQ-024 No eligible entry with ready high: work<=0; other outputs hold.
REQ-025 Latency: operands ready at dispatch edge N -> work high after edge N+1.
REQ-026 ready low: entries, work and outputs hold; dispatch and wakeups ignored.
REQ-027 clear (ignores ready): all entries invalid, work<=0 at the edge; same-cycle dispatch dropped.

Reset
REQ-028 reset_n low: all entries invalid, work=0, op/imm/pc/robpos/rs1/rs2=0, rs_full=0, age state cleared.
REQ-029 Reset mid-operation discards pending entries; first edge after release accepts dispatch.

Configuration
REQ-030 ALU_RS_AGE_PRIO_EN defined: select oldest eligible entry by dispatch order; undefined: lowest eligible index, no age storage.

Structure
REQ-031 RS_SIZE default, RS_IDX_LEN and op encodings live in shared def.v.
REQ-032 Selection logic in sub-module alu_rs_select (eligible vector, optional age state -> one-hot grant, grant valid).

Verification
REQ-033 Reset, dispatch ADD robpos 3 vj=5 vk=7 -> work=1 with op ADD, rs1=5, rs2=7, robpos=3 after second edge.
REQ-034 Dispatch qj_busy qj=2; cdb1 robpos 2 val 0x10 two cycles later -> issue next cycle with rs1=0x10.
REQ-035 Fill 8 entries all waiting on tag 6 -> rs_full=1, 9th dispatch dropped; cdb0 robpos 6 -> eight issues on consecutive cycles.
REQ-036 Dispatch tags 5 then 4 into indices 1 and 0 order (index 1 first), both wake together -> with ALU_RS_AGE_PRIO_EN robpos 5 first, without robpos 4 first.
REQ-037 Four entries pending, clear pulse with in_valid high -> rs_full=0, work=0, nothing issued afterward.
REQ-038 ready low 3 cycles with eligible entry and CDB activity -> outputs frozen, no issue; issue resumes when ready returns.
